fifo_readout_arbiter: RTL and testbench

Round-robin read scheduler sharing one AXI-Stream-style output among N_CH channel threshold FIFOs. Watches each FIFO's NOT_EMPTY / ALMOST_FULL, grants one channel at a time for a burst of up to BURST_MAX words, drives that channel's RE, and forwards its first-word-fall-through DOUT with channel ID. Sits between the per-channel hit FIFOs and the readout/DMA path.

---
 rtl/fifo_arb_pkg.sv | 21 ++
 rtl/rr_priority_picker.sv | 30 +++
 rtl/fifo_readout_arbiter.sv | 120 ++++++++++++
 tb/tb_fifo_readout_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO readout arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v << 1) r++;
    return r;
  endfunction

  // Channel ID width: a single bit even when only one index would be needed.
  function automatic int ch_width(input int n_ch);
    return (clog2(n_ch) < 1) ? 1 : clog2(n_ch);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin pick: first set request bit after last_i, wrapping modulo N_CH.
module rr_priority_picker
  import fifo_arb_pkg::*;
#(
  parameter  int N_CH = 4,
  localparam int CH_W = ch_width(N_CH)
) (
  input  logic [N_CH-1:0] req_i,
  input  logic [CH_W-1:0] last_i,
  output logic            found_o,
  output logic [CH_W-1:0] index_o
);

  logic [CH_W-1:0] cand;

  // NOTE: every output and temporary gets a default before any branch, so no latch is inferred.
  always_comb begin
    found_o = 1'b0;
    index_o = '0;
    cand    = '0;
    for (int off = 1; off <= N_CH; off++) begin
      cand = CH_W'((int'(last_i) + off) % N_CH);
      if (!found_o && req_i[cand]) begin
        found_o = 1'b1;
        index_o = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_readout_arbiter.sv
// Round-robin burst scheduler draining N_CH FWFT FIFOs onto one stream output.
module fifo_readout_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int N_CH      = 4,
  parameter  int WIDTH     = 64,
  parameter  int BURST_MAX = 16,
  localparam int CH_W      = ch_width(N_CH)
) (
  input  logic                    CLK,
  input  logic                    RESETN,
  input  logic [N_CH*WIDTH-1:0]   FIFO_DOUT,
  input  logic [N_CH-1:0]         FIFO_NOT_EMPTY,
  input  logic [N_CH-1:0]         FIFO_ALMOST_FULL,
  output logic [N_CH-1:0]         FIFO_RE,
  input  logic [N_CH-1:0]         CH_ENABLE,
  output logic [WIDTH-1:0]        M_TDATA,
  output logic                    M_TVALID,
  input  logic                    M_TREADY,
  output logic [CH_W-1:0]         M_TUSER,
  output logic                    M_TLAST,
  output logic                    BUSY
);

  localparam int              BC_W      = clog2(BURST_MAX + 1);
  localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(BURST_MAX - 1);

  state_e          state_q, state_d;
  logic [CH_W-1:0] grant_q, grant_d;
  logic [CH_W-1:0] last_grant_q, last_grant_d;
  logic [BC_W-1:0] beat_q, beat_d;

  logic [N_CH-1:0] req_af, req_ne;
  logic            af_found, ne_found;
  logic [CH_W-1:0] af_idx, ne_idx;
  logic            head_valid;
  logic            accept;

  assign req_af = FIFO_ALMOST_FULL & FIFO_NOT_EMPTY & CH_ENABLE;
  assign req_ne = FIFO_NOT_EMPTY & CH_ENABLE;

  rr_priority_picker #(.N_CH(N_CH)) u_pick_af (
    .req_i   (req_af),
    .last_i  (last_grant_q),
    .found_o (af_found),
    .index_o (af_idx)
  );

  rr_priority_picker #(.N_CH(N_CH)) u_pick_ne (
    .req_i   (req_ne),
    .last_i  (last_grant_q),
    .found_o (ne_found),
    .index_o (ne_idx)
  );

  assign head_valid = FIFO_NOT_EMPTY[grant_q];
  assign accept     = (state_q == XFER) && head_valid && M_TREADY;
  assign BUSY       = (state_q == XFER);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= CH_W'(N_CH - 1);
      beat_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_q       <= beat_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_d       = beat_q;
    M_TVALID     = 1'b0;
    M_TDATA      = '0;
    M_TLAST      = 1'b0;
    M_TUSER      = grant_q;
    FIFO_RE      = '0;

    unique case (state_q)
      IDLE: begin
        // Almost-full channels pre-empt ordinary requesters to avoid overflow.
        if (af_found) begin
          grant_d      = af_idx;
          last_grant_d = af_idx;
          beat_d       = '0;
          state_d      = XFER;
        end else if (ne_found) begin
          grant_d      = ne_idx;
          last_grant_d = ne_idx;
          beat_d       = '0;
          state_d      = XFER;
        end
      end

      XFER: begin
        M_TVALID         = head_valid;
        M_TDATA          = FIFO_DOUT[grant_q*WIDTH +: WIDTH];
        M_TLAST          = head_valid && (beat_q == LAST_BEAT);
        FIFO_RE[grant_q] = accept;
        if (accept && (beat_q == LAST_BEAT)) begin
          state_d = IDLE;
        end else if (!head_valid) begin
          state_d = IDLE;
        end else if (accept) begin
          beat_d = beat_q + BC_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_readout_arbiter.sv
// Directed bench: behavioural FWFT FIFOs per channel, beat monitor, hand-computed expectations.
module tb_fifo_readout_arbiter;

  localparam int N  = 4;
  localparam int W  = 64;
  localparam int BM = 4;

  logic           CLK = 1'b0;
  logic           RESETN;
  logic [N*W-1:0] fifo_dout;
  logic [N-1:0]   fifo_ne;
  logic [N-1:0]   fifo_af;
  logic [N-1:0]   FIFO_RE;
  logic [N-1:0]   CH_ENABLE;
  logic [W-1:0]   M_TDATA;
  logic           M_TVALID;
  logic           M_TREADY;
  logic [1:0]     M_TUSER;
  logic           M_TLAST;
  logic           BUSY;

  fifo_readout_arbiter #(.N_CH(N), .WIDTH(W), .BURST_MAX(BM)) dut (
    .CLK              (CLK),
    .RESETN           (RESETN),
    .FIFO_DOUT        (fifo_dout),
    .FIFO_NOT_EMPTY   (fifo_ne),
    .FIFO_ALMOST_FULL (fifo_af),
    .FIFO_RE          (FIFO_RE),
    .CH_ENABLE        (CH_ENABLE),
    .M_TDATA          (M_TDATA),
    .M_TVALID         (M_TVALID),
    .M_TREADY         (M_TREADY),
    .M_TUSER          (M_TUSER),
    .M_TLAST          (M_TLAST),
    .BUSY             (BUSY)
  );

  always #5 CLK = ~CLK;

  // Behavioural FIFOs: registered not-empty and head word reflect post-pop occupancy.
  logic [W-1:0] mem [N][64];
  int           rp [N];
  int           wp [N];
  int           pop_empty = 0;

  always @(posedge CLK) begin
    for (int c = 0; c < N; c++) begin
      int r;
      r = rp[c];
      if (FIFO_RE[c]) begin
        if (r != wp[c]) r = r + 1;
        else pop_empty = pop_empty + 1;
      end
      rp[c]              <= r;
      fifo_ne[c]         <= (r != wp[c]);
      fifo_dout[c*W +: W] <= mem[c][r[5:0]];
    end
  end

  typedef struct {
    logic [1:0]   user;
    logic [W-1:0] data;
    logic         last;
    int           cyc;
  } beat_t;

  beat_t obs[$];
  int    cyc = 0;

  always @(negedge CLK) begin
    cyc = cyc + 1;
    if (M_TVALID && M_TREADY) obs.push_back('{M_TUSER, M_TDATA, M_TLAST, cyc});
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] word(input int c, input int i);
    return 64'hA5A5_0000_0000_0000 | (64'(c) << 16) | 64'(i);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load(input int c, input int first, input int n);
    for (int i = 0; i < n; i++) begin
      mem[c][wp[c][5:0]] = word(c, first + i);
      wp[c] = wp[c] + 1;
    end
  endtask

  function automatic bit work_left();
    bit w;
    w = 1'b0;
    for (int c = 0; c < N; c++)
      if (CH_ENABLE[c] && (wp[c] != rp[c])) w = 1'b1;
    return w;
  endfunction

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((BUSY || work_left()) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) check({tag, "_timeout"}, 128'(n), 128'(0));
  endtask

  task automatic wait_beats(input string tag, input int cnt, input int budget);
    int n;
    n = 0;
    while (obs.size() < cnt && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) check({tag, "_timeout"}, 128'(obs.size()), 128'(cnt));
  endtask

  task automatic expect_beat(input string tag, input int k, input int c, input int i,
                             input logic last);
    if (k < obs.size())
      check($sformatf("%s[%0d]", tag, k),
            128'({obs[k].user, obs[k].last, obs[k].data}),
            128'({2'(c), last, word(c, i)}));
    else
      check($sformatf("%s[%0d]_missing", tag, k), 128'(obs.size()), 128'(k + 1));
  endtask

  task automatic expect_gap(input string tag, input int k, input int gap);
    if (k + 1 < obs.size())
      check(tag, 128'(obs[k+1].cyc - obs[k].cyc), 128'(gap));
    else
      check({tag, "_missing"}, 128'(obs.size()), 128'(k + 2));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESETN    = 1'b0;
    CH_ENABLE = '0;
    fifo_af   = '0;
    M_TREADY  = 1'b1;
    repeat (3) tick();

    // Reset state.
    check("rst_tvalid", 128'(M_TVALID), 128'(0));
    check("rst_re",     128'(FIFO_RE),  128'(0));
    check("rst_tlast",  128'(M_TLAST),  128'(0));
    check("rst_busy",   128'(BUSY),     128'(0));
    check("rst_tdata",  128'(M_TDATA),  128'(0));
    check("rst_tuser",  128'(M_TUSER),  128'(0));
    RESETN    = 1'b1;
    CH_ENABLE = 4'b1111;

    // Single channel: ch2 holds A,B,C.
    obs.delete();
    load(2, 0, 3);
    tick();
    check("t1_idle_busy",   128'(BUSY),     128'(0));
    check("t1_idle_tvalid", 128'(M_TVALID), 128'(0));
    tick();
    check("t1_first_tvalid", 128'(M_TVALID), 128'(1));
    check("t1_first_tuser",  128'(M_TUSER),  128'(2));
    check("t1_first_tdata",  128'(M_TDATA),  128'(word(2, 0)));
    check("t1_first_re",     128'(FIFO_RE),  128'(4'b0100));
    drain("t1", 50);
    check("t1_count", 128'(obs.size()), 128'(3));
    for (int k = 0; k < 3; k++) expect_beat("t1_beat", k, 2, k, 1'b0);
    expect_gap("t1_gap01", 0, 1);
    expect_gap("t1_gap12", 1, 1);

    // Burst cap: ch0 holds 10 words, BURST_MAX=4.
    obs.delete();
    load(0, 0, 10);
    drain("t2", 100);
    check("t2_count", 128'(obs.size()), 128'(10));
    for (int k = 0; k < 10; k++) expect_beat("t2_beat", k, 0, k, (k == 3) || (k == 7));
    expect_gap("t2_gap01", 0, 1);
    expect_gap("t2_bubble34", 3, 2);
    expect_gap("t2_bubble78", 7, 2);

    // Round robin from a fresh reset: order 0,1,2,3.
    RESETN = 1'b0;
    tick();
    RESETN = 1'b1;
    obs.delete();
    load(0, 10, 2);
    load(1, 0, 2);
    load(2, 3, 2);
    load(3, 0, 2);
    drain("t3", 100);
    check("t3_count", 128'(obs.size()), 128'(8));
    expect_beat("t3_beat", 0, 0, 10, 1'b0);
    expect_beat("t3_beat", 1, 0, 11, 1'b0);
    expect_beat("t3_beat", 2, 1, 0,  1'b0);
    expect_beat("t3_beat", 3, 1, 1,  1'b0);
    expect_beat("t3_beat", 4, 2, 3,  1'b0);
    expect_beat("t3_beat", 5, 2, 4,  1'b0);
    expect_beat("t3_beat", 6, 3, 0,  1'b0);
    expect_beat("t3_beat", 7, 3, 1,  1'b0);

    // Almost-full priority: last_grant=0, ch1 and ch3 pending, ch3 almost full.
    obs.delete();
    load(0, 12, 1);
    drain("t4a", 50);
    obs.delete();
    fifo_af = 4'b1000;
    load(1, 2, 2);
    load(3, 2, 2);
    drain("t4", 100);
    fifo_af = 4'b0000;
    check("t4_count", 128'(obs.size()), 128'(4));
    expect_beat("t4_beat", 0, 3, 2, 1'b0);
    expect_beat("t4_beat", 1, 3, 3, 1'b0);
    expect_beat("t4_beat", 2, 1, 2, 1'b0);
    expect_beat("t4_beat", 3, 1, 3, 1'b0);

    // Backpressure: stall 5 cycles after two accepted beats.
    obs.delete();
    load(1, 4, 5);
    wait_beats("t5", 2, 50);
    M_TREADY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("t5_hold_tvalid%0d", i), 128'(M_TVALID), 128'(1));
      check($sformatf("t5_hold_tdata%0d", i),  128'(M_TDATA),  128'(word(1, 6)));
      check($sformatf("t5_hold_re%0d", i),     128'(FIFO_RE),  128'(0));
      tick();
    end
    M_TREADY = 1'b1;
    drain("t5", 100);
    check("t5_count", 128'(obs.size()), 128'(5));
    for (int k = 0; k < 5; k++) expect_beat("t5_beat", k, 1, 4 + k, k == 3);

    // Mask: ch0 disabled with data present, ch2 enabled.
    obs.delete();
    CH_ENABLE = 4'b1110;
    load(0, 13, 2);
    load(2, 5, 1);
    drain("t6", 50);
    repeat (10) tick();
    check("t6_busy", 128'(BUSY), 128'(0));
    check("t6_count", 128'(obs.size()), 128'(1));
    expect_beat("t6_beat", 0, 2, 5, 1'b0);

    // Reset mid-burst on ch3, then lowest requester (ch0) goes first.
    obs.delete();
    load(3, 4, 3);
    wait_beats("t7", 1, 50);
    check("t7_pre_tvalid", 128'(M_TVALID), 128'(1));
    RESETN = 1'b0;
    #1;
    check("t7_rst_tvalid", 128'(M_TVALID), 128'(0));
    check("t7_rst_re",     128'(FIFO_RE),  128'(0));
    check("t7_rst_busy",   128'(BUSY),     128'(0));
    CH_ENABLE = 4'b1111;
    obs.delete();
    tick();
    tick();
    RESETN = 1'b1;
    drain("t7", 100);
    check("t7_count", 128'(obs.size()), 128'(4));
    expect_beat("t7_beat", 0, 0, 13, 1'b0);
    expect_beat("t7_beat", 1, 0, 14, 1'b0);
    expect_beat("t7_beat", 2, 3, 5,  1'b0);
    expect_beat("t7_beat", 3, 3, 6,  1'b0);

    check("no_pop_when_empty", 128'(pop_empty), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
